bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Memory-mapped timer peripheral that acts as a responder on the Bridge's peripheral port.
- The CPU issues single-cycle loads and stores through the Bridge. The Bridge decodes the timer window and drives sel_from_bridge plus a word offset.
- The block contains a prescaler, a 32-bit up-counter, a compare register and a sticky match flag with interrupt output.
- Reads are combinational, matching DRAM spo timing. Writes commit on the rising clock edge.

Parameters:
- PRESCALE_RST, 32'd0, reset value of PRESCALE.
- CMP_RST, 32'hFFFF_FFFF, reset value of CMP.

Ports:
- clk_from_bridge  input  1  clock (same clock as cpu_clk)
- rst_from_bridge  input  1  synchronous, active-high reset
- sel_from_bridge  input  1  timer window selected this cycle
- addr_from_bridge  input  5  byte offset within window; bits [1:0] ignored
- we_from_bridge  input  1  store strobe; effective only when sel_from_bridge=1
- wdata_from_bridge  input  32  store data
- rdata_to_bridge  output  32  load data (combinational)
- irq_to_cpu  output  1  MATCH & CTRL.IE

Behaviour:
- Register map, by word offset:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IE. Other bits read 0.
  - 0x04 PRESCALE
  - 0x08 COUNT
  - 0x0C CMP
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear. Other bits read 0.
  - 0x14 to 0x1C: unmapped. Reads return 0; writes are ignored.
- Read path:
  - rdata_to_bridge = selected register when sel_from_bridge=1, else 32'd0.
  - No cycle latency.
  - A read returns the value before any same-edge write.
- Write path: a write occurs when sel & we at the rising edge. The new value is visible on a read in the next cycle.
- Reset (synchronous, when rst_from_bridge=1 at the edge):
  - CTRL=0, PRESCALE=PRESCALE_RST, COUNT=0, CMP=CMP_RST, MATCH=0, prescaler counter pcnt=0.
  - Therefore irq_to_cpu=0, and rdata_to_bridge reflects the reset values.
  - Reset overrides every concurrent write and tick.
- Prescaler:
  - When EN=1: if pcnt==PRESCALE, then pcnt<=0 and tick=1; otherwise pcnt<=pcnt+1 and tick=0.
  - When EN=0: pcnt holds and tick=0.
  - PRESCALE=0 gives a tick every cycle. PRESCALE=N gives a tick every N+1 cycles.
  - Writing PRESCALE forces pcnt<=0 at the same edge.
  - If the PRESCALE write is smaller than the current pcnt, no wrap-around wait occurs, because pcnt is reset.
- Counter, on each tick:
  - If COUNT==CMP: MATCH<=1, and COUNT<=(AUTO_RELOAD ? 0 : COUNT+1).
  - Otherwise: COUNT<=COUNT+1, with modulo 2^32 wrap (0xFFFF_FFFF -> 0). The wrap by itself sets no flag.
- Simultaneous events:
  - A write to COUNT on a tick edge: the written value wins and the tick's update is discarded. The compare uses the pre-write COUNT.
  - A write to CMP on a tick edge: the compare uses the old CMP.
  - MATCH set and a W1C on the same edge: set wins, and MATCH stays 1.
  - A write to CTRL with EN=0 on a tick edge: that tick still takes effect. Counting stops from the next cycle.
- irq_to_cpu is registered-flag derived and purely combinational from MATCH and IE. It carries no additional latency.

Decomposition:
- Shared package timer_defs:
  - Offset constants TMR_CTRL, TMR_PRESCALE, TMR_COUNT, TMR_CMP, TMR_STATUS.
  - CTRL bit indices EN_BIT, AR_BIT, IE_BIT.
  - The window base address used by the Bridge decoder.
- One sub-module is natural: timer_prescaler.
  - Inputs: clk, rst, en, prescale, reload strobe.
  - Output: tick.
  - It owns pcnt.
- bus_timer holds the register file, the counter/compare logic and the read mux.

Test Plan:
1. Reset and reads:
   - Stimulus: assert rst_from_bridge for 2 cycles, then read every offset.
   - Required response: CTRL=0, PRESCALE=0, COUNT=0, CMP=0xFFFFFFFF, STATUS=0, unmapped=0, irq_to_cpu=0.
   - Also: with sel=0, rdata=0.
2. Prescale timing:
   - Stimulus: write PRESCALE=3, then CTRL=1.
   - Required response: COUNT increments exactly every 4 cycles. After 40 enabled cycles, COUNT=10.
   - Then write CTRL=0: COUNT freezes, and pcnt resumes from its held value when re-enabled.
3. Compare with auto-reload:
   - Stimulus: write CMP=5, PRESCALE=0, CTRL=0x7.
   - Required response: COUNT sequence 0,1,2,3,4,5,0,1…, with MATCH=1 and irq_to_cpu=1 from the edge where 5->0.
   - Then write STATUS=1: MATCH=0 and irq=0 the next cycle.
4. No reload and wrap:
   - Stimulus: CTRL=0x1, write COUNT=0xFFFFFFFE, CMP=0xFFFFFFFF.
   - Required response: COUNT=0xFFFFFFFF, then 0, then 1. MATCH is set on the 0xFFFFFFFF->0 tick. irq_to_cpu stays 0 because IE=0.
5. Collisions:
   - Write COUNT=0x100 on a tick edge: COUNT reads 0x100 next cycle, not old+1.
   - Issue a W1C of STATUS on the same edge as a match: MATCH reads 1.
6. Reset mid-count:
   - Stimulus: with EN=1, PRESCALE=2, COUNT=7, pulse rst_from_bridge for 1 cycle.
   - Required response: all registers return to reset values and counting stops, because EN=0 after reset.

Source files
------------

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register word offsets,
// CTRL bit positions and the window base used by the Bridge decoder.
package timer_defs;

    localparam logic [31:0] TMR_BASE = 32'h4000_1000;

    // Word offsets (byte offset >> 2)
    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESCALE = 3'd1;
    localparam logic [2:0] TMR_COUNT    = 3'd2;
    localparam logic [2:0] TMR_CMP      = 3'd3;
    localparam logic [2:0] TMR_STATUS   = 3'd4;

    localparam int EN_BIT = 0;
    localparam int AR_BIT = 1;
    localparam int IE_BIT = 2;

    typedef struct packed {
        logic        wr;
        logic [2:0]  idx;
        logic [31:0] data;
    } bus_req_t;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for the bus timer: emits a one-cycle tick every PRESCALE+1
// enabled cycles and owns the prescale counter.
module timer_prescaler
    import timer_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] prescale,
    input  logic        reload,
    output logic        tick
);

    logic [31:0] pcnt;

    // Tick compares against the pre-write PRESCALE; a concurrent PRESCALE
    // write still restarts the count from zero.
    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= 32'd0;
        end else if (reload || tick) begin
            pcnt <= 32'd0;
        end else if (en) begin
            pcnt <= pcnt + 32'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer responder: register file, 32-bit counter with
// compare/auto-reload, sticky MATCH flag and combinational read mux.
module bus_timer
    import timer_defs::*;
#(
    parameter logic [31:0] PRESCALE_RST = 32'd0,
    parameter logic [31:0] CMP_RST      = 32'hFFFF_FFFF
) (
    input  logic        clk_from_bridge,
    input  logic        rst_from_bridge,
    input  logic        sel_from_bridge,
    input  logic [4:0]  addr_from_bridge,
    input  logic        we_from_bridge,
    input  logic [31:0] wdata_from_bridge,
    output logic [31:0] rdata_to_bridge,
    output logic        irq_to_cpu
);

    logic [2:0]  ctrl;
    logic [31:0] prescale;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        tick;
    logic        hit;
    bus_req_t    req;
    logic        addr_unused;

    assign addr_unused = &addr_from_bridge[1:0];

    assign req.wr   = sel_from_bridge && we_from_bridge;
    assign req.idx  = addr_from_bridge[4:2];
    assign req.data = wdata_from_bridge;

    logic wr_ctrl, wr_prescale, wr_count, wr_cmp, wr_status;
    assign wr_ctrl     = req.wr && (req.idx == TMR_CTRL);
    assign wr_prescale = req.wr && (req.idx == TMR_PRESCALE);
    assign wr_count    = req.wr && (req.idx == TMR_COUNT);
    assign wr_cmp      = req.wr && (req.idx == TMR_CMP);
    assign wr_status   = req.wr && (req.idx == TMR_STATUS);

    timer_prescaler u_prescaler (
        .clk      (clk_from_bridge),
        .rst      (rst_from_bridge),
        .en       (ctrl[EN_BIT]),
        .prescale (prescale),
        .reload   (wr_prescale),
        .tick     (tick)
    );

    // Compare sees the pre-edge COUNT and CMP, so same-edge writes never
    // affect this cycle's match decision.
    assign hit = tick && (count == cmp);

    always_ff @(posedge clk_from_bridge) begin
        if (rst_from_bridge) begin
            ctrl     <= 3'd0;
            prescale <= PRESCALE_RST;
            count    <= 32'd0;
            cmp      <= CMP_RST;
            match    <= 1'b0;
        end else begin
            if (wr_ctrl)     ctrl     <= req.data[2:0];
            if (wr_prescale) prescale <= req.data;
            if (wr_cmp)      cmp      <= req.data;

            if (wr_count)
                count <= req.data;
            else if (hit && ctrl[AR_BIT])
                count <= 32'd0;
            else if (tick)
                count <= count + 32'd1;

            // Set beats a concurrent write-1-to-clear
            if (hit)
                match <= 1'b1;
            else if (wr_status && req.data[0])
                match <= 1'b0;
        end
    end

    always_comb begin
        rdata_to_bridge = 32'd0;
        if (sel_from_bridge) begin
            unique case (req.idx)
                TMR_CTRL:     rdata_to_bridge = {29'd0, ctrl};
                TMR_PRESCALE: rdata_to_bridge = prescale;
                TMR_COUNT:    rdata_to_bridge = count;
                TMR_CMP:      rdata_to_bridge = cmp;
                TMR_STATUS:   rdata_to_bridge = {31'd0, match};
                default:      rdata_to_bridge = 32'd0;
            endcase
        end
    end

    assign irq_to_cpu = match && ctrl[IE_BIT];

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: read stimulus pushes expected data into a
// queue; a negedge monitor pops and compares whenever a read is presented.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    logic        mon_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        bit          chk_irq;
        bit          irq;
        string       name;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] A_CTRL = 5'h00, A_PRE = 5'h04, A_CNT = 5'h08,
                           A_CMP = 5'h0C, A_STAT = 5'h10;

    bus_timer dut (
        .clk_from_bridge   (clk),
        .rst_from_bridge   (rst),
        .sel_from_bridge   (sel),
        .addr_from_bridge  (addr),
        .we_from_bridge    (we),
        .wdata_from_bridge (wdata),
        .rdata_to_bridge   (rdata),
        .irq_to_cpu        (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_req) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: read presented with no expectation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if (rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL %s: rdata got %h expected %h", e.name, rdata, e.data);
                end
                if (e.chk_irq) begin
                    n_tests++;
                    if (irq !== e.irq) begin
                        n_fail++;
                        $display("FAIL %s_irq: irq got %b expected %b", e.name, irq, e.irq);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic w,
                       input logic [4:0] a, input logic [31:0] d, input logic m);
        @(posedge clk);
        #1;
        rst = r; sel = s; we = w; addr = a; wdata = d; mon_req = m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic reset_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd_x(input logic s, input logic [4:0] a, input logic [31:0] e,
                        input string name, input bit ci, input bit ei);
        exp_t x;
        x.data = e; x.chk_irq = ci; x.irq = ei; x.name = name;
        sb.push_back(x);
        cyc(1'b0, s, 1'b0, a, 32'hDEAD_BEEF, 1'b1);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string name);
        rd_x(1'b1, a, e, name, 1'b0, 1'b0);
    endtask

    task automatic rdi(input logic [4:0] a, input logic [31:0] e, input string name,
                       input bit ei);
        rd_x(1'b1, a, e, name, 1'b1, ei);
    endtask

    initial begin
        // 1. Reset values and read mux
        reset_n(2);
        rdi(A_CTRL, 32'd0, "rst_ctrl", 1'b0);
        rd(A_PRE,  32'd0,          "rst_prescale");
        rd(A_CNT,  32'd0,          "rst_count");
        rd(A_CMP,  32'hFFFF_FFFF,  "rst_cmp");
        rd(A_STAT, 32'd0,          "rst_status");
        rd(5'h14,  32'd0,          "unmapped_14");
        rd(5'h18,  32'd0,          "unmapped_18");
        rd(5'h1C,  32'd0,          "unmapped_1c");
        rd_x(1'b0, A_CMP, 32'd0, "nosel_zero", 1'b0, 1'b0);
        wr(5'h18, 32'h1234_5678);
        rd(5'h18,  32'd0,          "unmapped_wr_ignored");
        rd(A_CMP,  32'hFFFF_FFFF,  "cmp_after_unmapped_wr");

        // 2. Prescale=3: one increment per 4 enabled edges
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'd1);
        for (int i = 0; i <= 10; i++) begin
            rd(A_CNT, i, "prescale_count");
            if (i < 10) idle(3);
        end
        wr(A_CTRL, 32'd0);          // pcnt held at 2
        idle(5);
        rd(A_CNT, 32'd10, "frozen_count");
        wr(A_CTRL, 32'd1);
        rd(A_CNT, 32'd10, "resume_a");
        rd(A_CNT, 32'd10, "resume_b");
        rd(A_CNT, 32'd11, "resume_tick");

        // 3. Compare with auto-reload and IRQ
        reset_n(1);
        wr(A_CMP, 32'd5);
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h7);
        rdi(A_CNT, 32'd0, "ar_seq0", 1'b0);
        rdi(A_CNT, 32'd1, "ar_seq1", 1'b0);
        rdi(A_CNT, 32'd2, "ar_seq2", 1'b0);
        rdi(A_CNT, 32'd3, "ar_seq3", 1'b0);
        rdi(A_CNT, 32'd4, "ar_seq4", 1'b0);
        rdi(A_CNT, 32'd5, "ar_seq5", 1'b0);
        rdi(A_CNT, 32'd0, "ar_reload", 1'b1);
        rdi(A_CNT, 32'd1, "ar_seq7", 1'b1);
        wr(A_STAT, 32'd1);
        rdi(A_STAT, 32'd0, "w1c_clear", 1'b0);

        // 4. No reload, wrap through 0xFFFFFFFF with match, IE=0
        reset_n(1);
        wr(A_CMP, 32'hFFFF_FFFF);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        rd(A_CNT, 32'hFFFF_FFFE, "wrap_fe");
        rd(A_CNT, 32'hFFFF_FFFF, "wrap_ff");
        rd(A_CNT, 32'd0,         "wrap_0");
        rd(A_CNT, 32'd1,         "wrap_1");
        rdi(A_STAT, 32'd1, "wrap_match", 1'b0);

        // Plain wrap without a compare hit sets nothing
        reset_n(1);
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h5);
        rd(A_CNT, 32'hFFFF_FFFF, "nomatch_ff");
        rd(A_CNT, 32'd0,         "nomatch_0");
        rdi(A_STAT, 32'd0, "nomatch_status", 1'b0);

        // 5. Collisions
        reset_n(1);
        wr(A_CTRL, 32'h1);
        rd(A_CNT, 32'd0, "col_cnt0");
        wr(A_CNT, 32'h100);
        rd(A_CNT, 32'h100, "col_count_wr");
        rd(A_CNT, 32'h101, "col_count_next");

        reset_n(1);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h5);
        rd(A_CNT, 32'd0, "w1c_col_cnt0");
        idle(2);
        wr(A_STAT, 32'd1);          // lands on the 3->4 match edge
        rdi(A_STAT, 32'd1, "w1c_col_set_wins", 1'b1);
        rd(A_CNT, 32'd5, "w1c_col_no_reload");

        reset_n(1);
        wr(A_CTRL, 32'h1);
        rd(A_CNT, 32'd0, "en_off_cnt0");
        wr(A_CTRL, 32'h0);          // tick on this edge still counts
        rd(A_CNT, 32'd2, "en_off_last_tick");
        rd(A_CNT, 32'd2, "en_off_frozen");

        reset_n(1);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h1);
        idle(2);
        wr(A_CMP, 32'd9);           // edge compares count 2 against old CMP
        rd(A_STAT, 32'd1, "cmp_wr_old_used");

        // 6. Reset mid-count
        reset_n(1);
        wr(A_PRE, 32'd2);
        wr(A_CNT, 32'd7);
        wr(A_CTRL, 32'h5);
        idle(4);
        rd(A_CNT, 32'd8, "pre2_count");
        reset_n(1);
        rdi(A_CTRL, 32'd0, "mid_rst_ctrl", 1'b0);
        rd(A_PRE,  32'd0,         "mid_rst_prescale");
        rd(A_CNT,  32'd0,         "mid_rst_count");
        rd(A_CMP,  32'hFFFF_FFFF, "mid_rst_cmp");
        rd(A_STAT, 32'd0,         "mid_rst_status");
        idle(3);
        rd(A_CNT,  32'd0,         "mid_rst_stopped");

        idle(2);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
